// File: rtl/sync_fifo_flags_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags_if
// Description : Handshake/status bundle between sync_fifo_flags and its users.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [c_CW-1:0]       count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, data_in, r_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  w_en, data_in, r_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags
// Description : Single-clock FIFO with wrap-bit pointers, occupancy count,
//               almost flags, error pulses and optional FWFT read.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  wire                   clk,
  input  wire                   rst,
  sync_fifo_flags_if.slave      bus
);
  localparam int              c_AW = $clog2(DEPTH);
  localparam int              c_PW = c_AW + 1;
  localparam logic [c_PW-1:0] c_AF = c_PW'(AF_LEVEL);
  localparam logic [c_PW-1:0] c_AE = c_PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]       r_wptr;
  logic [c_PW-1:0]       r_rptr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [c_PW-1:0]       w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_head;

  // Wrap bit distinguishes full (same slot, different lap) from empty.
  assign w_count  = r_wptr - r_rptr;
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]) &&
                    (r_wptr[c_AW] != r_rptr[c_AW]);
  assign w_wr_acc = bus.w_en & ~w_full;
  assign w_rd_acc = bus.r_en & ~w_empty;
  assign w_head   = r_mem[r_rptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_overflow  <= bus.w_en & w_full;
      r_underflow <= bus.r_en & w_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) r_mem[r_wptr[c_AW-1:0]] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; zero while empty.
      assign bus.data_out = w_empty ? '0 : w_head;
      assign bus.rd_valid = ~w_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_data_out;
      logic                  r_rd_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_data_out <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_data_out <= w_head;
        end
      end

      assign bus.data_out = r_data_out;
      assign bus.rd_valid = r_rd_valid;
    end
  endgenerate

  assign bus.count        = w_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = (w_count >= c_AF);
  assign bus.almost_empty = (w_count <= c_AE);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule
`default_nettype wire
